// File: rtl/read_fifo_register.sv
// Z80-readable byte FIFO: peripheral pushes bytes, each rising edge of i_read_strobe pops one.
// Optional fill-level interrupt is built only when READ_FIFO_IRQ_EN is defined.
module read_fifo_register #(
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned IRQ_LEVEL = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    output logic       o_push_ready,
    input  logic       i_read_strobe,
    input  logic       i_status_clear,
    output logic [7:0] o_data_out,
    output logic [7:0] o_status_out,
    output logic       o_irq
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};

    logic [7:0]           r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS:0]   r_count;
    logic                 r_overflow;
    logic                 r_underflow;
    logic                 r_rs_prev;

    logic       w_pop;
    logic       w_empty;
    logic       w_full;
    logic       w_push_acc;
    logic       w_pop_acc;
    logic       w_overflow_set;
    logic       w_underflow_set;
    logic [4:0] w_count_ext;
    logic [3:0] w_count_sat;

    always_comb begin
        w_pop           = i_read_strobe & ~r_rs_prev;
        w_empty         = (r_count == '0);
        w_full          = (r_count == DEPTH_CNT);
        // A pop in the same cycle frees the slot the push needs.
        w_push_acc      = i_push & (~w_full | w_pop);
        w_pop_acc       = w_pop & ~w_empty;
        w_overflow_set  = i_push & w_full & ~w_pop;
        w_underflow_set = w_pop & w_empty;
        w_count_ext     = 5'(r_count);
        w_count_sat     = w_count_ext[4] ? 4'hF : w_count_ext[3:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_rs_prev   <= 1'b0;
        end else begin
            r_rs_prev   <= i_read_strobe;
            r_overflow  <= w_overflow_set | (r_overflow & ~i_status_clear);
            r_underflow <= w_underflow_set | (r_underflow & ~i_status_clear);
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + (ADDR_BITS + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_BITS + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push_acc) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_comb begin
        o_data_out   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
        o_status_out = {w_count_sat, r_underflow, r_overflow, w_full, ~w_empty};
        o_push_ready = ~w_full;
    end

`ifdef READ_FIFO_IRQ_EN
    logic r_irq;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (32'(r_count) >= IRQ_LEVEL);
        end
    end

    assign o_irq = r_irq & ~i_reset;
`else
    logic w_unused_irq_level;

    assign w_unused_irq_level = ^IRQ_LEVEL;
    assign o_irq              = 1'b0;
`endif

endmodule
